// File: rtl/hdbn_sub_encoder.sv
// HDBn zero-substitution encoder with AMI polarity rails.
// Runs of ORDER+1 zeros become 0..0V or B0..0V.
module hdbn_sub_encoder #(
  parameter int ORDER = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_pos,
  output logic       out_neg
);

  localparam int ZW = $clog2(ORDER + 1);
  localparam int FW = $clog2(ORDER + 2);

  localparam logic [1:0] S_ZERO = 2'b00;
  localparam logic [1:0] S_MARK = 2'b01;
  localparam logic [1:0] S_V    = 2'b11;
  localparam logic [1:0] S_B    = 2'b10;

  logic [1:0]    sr    [ORDER+1];
  logic [1:0]    sr_nx [ORDER+1];
  logic [ZW-1:0] zcnt;
  logic [FW-1:0] fill;
  logic          par;
  logic          last_pol;

  logic          sub;
  logic          primed;
  logic [1:0]    head;
  logic          pos_nx;
  logic          neg_nx;
  logic          lp_nx;

  assign head   = sr[ORDER];
  assign primed = (fill == FW'(ORDER + 1));
  assign sub    = !in_bit && (zcnt == ZW'(ORDER));

  always_comb begin
    sr_nx[0] = sub ? S_V : {1'b0, in_bit};
    for (int i = 1; i <= ORDER; i++) begin
      sr_nx[i] = sr[i-1];
    end
    // B replaces the first zero of the run, now reaching the tail
    if (sub && !par) begin
      sr_nx[ORDER] = S_B;
    end
  end

  always_comb begin
    pos_nx = 1'b0;
    neg_nx = 1'b0;
    lp_nx  = last_pol;
    unique case (1'b1)
      (head == S_MARK),
      (head == S_B): begin
        pos_nx = ~last_pol;
        neg_nx = last_pol;
        lp_nx  = ~last_pol;
      end
      (head == S_V): begin
        pos_nx = last_pol;
        neg_nx = ~last_pol;
      end
      (head == S_ZERO): begin
        pos_nx = 1'b0;
        neg_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ORDER; i++) begin
        sr[i] <= S_ZERO;
      end
      zcnt      <= '0;
      fill      <= '0;
      par       <= 1'b0;
      last_pol  <= 1'b0;
      out_valid <= 1'b0;
      out_sym   <= S_ZERO;
      out_pos   <= 1'b0;
      out_neg   <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i <= ORDER; i++) begin
        sr[i] <= sr_nx[i];
      end
      unique case (1'b1)
        sub: begin
          zcnt <= '0;
          par  <= 1'b0;
        end
        in_bit: begin
          zcnt <= '0;
          par  <= ~par;
        end
        default: begin
          zcnt <= zcnt + 1'b1;
        end
      endcase
      if (!primed) begin
        fill <= fill + 1'b1;
      end
      out_valid <= primed;
      out_sym   <= head;
      out_pos   <= pos_nx;
      out_neg   <= neg_nx;
      last_pol  <= lp_nx;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdbn_sub_encoder.sv
// Bench for hdbn_sub_encoder: directed cases plus random streams
// checked against a run-length substitution model.
module tb_hdbn_sub_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;

  logic       v3, p3, n3;
  logic [1:0] s3;
  logic       v2, p2, n2;
  logic [1:0] s2;

  int cur_ord = 3;
  int n_assert = 0;
  int n_fail = 0;

  logic [1:0] got[$];

  always #5 clk = ~clk;

  hdbn_sub_encoder #(.ORDER(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(v3), .out_sym(s3), .out_pos(p3), .out_neg(n3)
  );

  hdbn_sub_encoder #(.ORDER(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(v2), .out_sym(s2), .out_pos(p2), .out_neg(n2)
  );

  logic       ov, op, on;
  logic [1:0] os;
  assign ov = (cur_ord == 3) ? v3 : v2;
  assign os = (cur_ord == 3) ? s3 : s2;
  assign op = (cur_ord == 3) ? p3 : p2;
  assign on = (cur_ord == 3) ? n3 : n2;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoded line symbols for the whole stream, then AMI pulses.
  task automatic run(input int ord, input bit bits[$], input int gap_pct);
    logic [1:0] sym[$];
    bit         epos[$];
    bit         eneg[$];
    int         zr;
    bit         p;
    bit         lp;
    int         j;
    bit         acc;
    logic       ev;
    logic [1:0] es;
    logic       ep, en;

    zr = 0;
    p = 0;
    foreach (bits[i]) begin
      if (bits[i]) begin
        sym.push_back(2'b01);
        zr = 0;
        p = ~p;
      end else begin
        sym.push_back(2'b00);
        zr++;
        if (zr == ord + 1) begin
          sym[i] = 2'b11;
          if (!p) sym[i-ord] = 2'b10;
          zr = 0;
          p = 0;
        end
      end
    end
    lp = 0;
    foreach (sym[i]) begin
      case (sym[i])
        2'b01, 2'b10: begin
          lp = ~lp;
          epos.push_back(lp);
          eneg.push_back(~lp);
        end
        2'b11: begin
          epos.push_back(lp);
          eneg.push_back(~lp);
        end
        default: begin
          epos.push_back(1'b0);
          eneg.push_back(1'b0);
        end
      endcase
    end

    cur_ord = ord;
    got.delete();
    rst = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {3'b0, ov}, 4'h0);
    chk("rst_sym", {2'b0, os}, 4'h0);
    chk("rst_pos", {3'b0, op}, 4'h0);
    chk("rst_neg", {3'b0, on}, 4'h0);

    es = 2'b00;
    ep = 1'b0;
    en = 1'b0;
    j = 0;
    while (j < bits.size()) begin
      acc = !(gap_pct > 0 && ($urandom % 100) < gap_pct);
      in_valid = acc;
      in_bit = acc ? bits[j] : 1'($urandom);
      @(posedge clk);
      #1;
      ev = 1'b0;
      if (acc) begin
        if (j >= ord + 1) begin
          ev = 1'b1;
          es = sym[j-ord-1];
          ep = epos[j-ord-1];
          en = eneg[j-ord-1];
        end else begin
          es = 2'b00;
          ep = 1'b0;
          en = 1'b0;
        end
        j++;
      end
      chk("out_valid", {3'b0, ov}, {3'b0, ev});
      chk("out_sym", {2'b0, os}, {2'b0, es});
      chk("out_pos", {3'b0, op}, {3'b0, ep});
      chk("out_neg", {3'b0, on}, {3'b0, en});
      chk("one_rail", {3'b0, op & on}, 4'h0);
      if (ov === 1'b1) got.push_back(os);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [1:0] e[$]);
    chk({tag, "_len"}, 4'(got.size()), 4'(e.size()));
    foreach (e[i]) begin
      if (i < got.size()) chk(tag, {2'b0, got[i]}, {2'b0, e[i]});
    end
  endtask

  initial begin
    bit         q[$];
    logic [1:0] e[$];

    q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0};
    run(3, q, 0);
    e = {2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};
    check_seq("eight_zeros", e);

    q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run(3, q, 0);
    e = {2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    check_seq("mark_000v", e);

    q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run(3, q, 0);
    e = {2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    check_seq("two_marks_b00v", e);

    run(3, q, 40);
    check_seq("gapped", e);

    q = {1'b0, 1'b0};
    run(3, q, 0);
    q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run(3, q, 0);
    e = {2'b10, 2'b00, 2'b00, 2'b11};
    check_seq("after_reset", e);

    q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run(2, q, 0);
    e = {2'b10, 2'b00, 2'b11};
    check_seq("order2", e);

    q.delete();
    for (int i = 0; i < 300; i++) q.push_back($urandom_range(0, 2) == 0);
    run(3, q, 30);

    q.delete();
    for (int i = 0; i < 200; i++) q.push_back($urandom_range(0, 2) == 0);
    run(2, q, 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
